gf_pe_lanes: RTL and testbench
==============================

# gf_pe_lanes

Multi-lane systolic processing element for GF(2^GF_BIT) matrix work in the signing/verification array. It generalises the single-element PE to LANES elements per word and registers every output for a clean pipeline boundary. It adds a valid/stall pipeline, an explicit pivot state machine and a sticky singular flag. Instances chain in a row or column: pivot-role PEs (`functionA`=1) find, normalise and broadcast pivots; follower PEs apply the broadcast operations to their LANES-wide row slice.

## Interface
- GF_BIT, 4, field width; legal values are 4 and 8. `USE_TOWER_FIELD` selects the tower basis, otherwise the AES polynomial.
- LANES, 4, GF elements per word, 1..8.
- OP_CODE_LEN, 4, opcode width; only bits [2:0] are decoded.
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  global advance; en=0 freezes all state and outputs.
- valid_in / valid_out  in/out  1  word qualifier.
- start_in / start_out, finish_in / finish_out  in/out  1  frame delimiters, valid-qualified.
- op_in / op_out  in/out  OP_CODE_LEN  operation.
- gauss_op_in / gauss_op_out  in/out  2  Gauss sub-op.
- functionA  in  1  role: 1 = pivot, 0 = follower. Static per frame.
- data_in / data_out  in/out  LANES*GF_BIT  row slice; lane l is bits [l*GF_BIT +: GF_BIT].
- dataB_in / dataB_out  in/out  GF_BIT  broadcast scalar.
- key_data  in  LANES*GF_BIT  key/coefficient slice.
- r  out  LANES*GF_BIT  accumulator register.
- singular  out  1  sticky flag: a frame finished with no pivot captured.

## Operation
- Opcodes (op_in[2:0]):
  - NOP=0: hold.
  - GAUSS=1: Gauss mode, see below.
  - LOAD=3: r <= key_data.
  - MAC=4: r[l] <= r[l] ^ dataB_in·key_data[l].
  - SWAP=5: r[0] <= dataB_in, dataB_out <= r[LANES-1], other lanes shift up by one. This forms a serial load/unload chain.
  - MULR=6: r[l] <= r[l] ^ dataB_in·data_in[l].
  - Other codes behave as NOP.
- Gauss sub-ops: PASS=00, NORM=01, ELIM=10, FLUSH=11.
- Pivot FSM, GAUSS with functionA=1. States EMPTY and HELD.
  - valid start_in → EMPTY, r <= 0, output word forwarded with PASS.
  - EMPTY, data_in[0]≠0 → r <= data_in, go to HELD. Emit NORM, dataB_out = inv(data_in[0]), data_out = data_in.
  - EMPTY, data_in[0]=0 → emit PASS, data_out = data_in.
  - HELD, any row → emit ELIM, dataB_out = data_in[0], data_out = data_in.
  - finish_in → emit FLUSH, data_out = r, go to EMPTY.
  - finish_in while EMPTY → also set singular.
  - start_in and finish_in in the same word: start wins, finish is forwarded unchanged.
- Follower, GAUSS with functionA=0. gauss_op_out = gauss_op_in, dataB_out = dataB_in.
  - PASS: data_out = data_in.
  - NORM: r[l] <= dataB_in·data_in[l], data_out = 0.
  - ELIM: data_out[l] = data_in[l] ^ dataB_in·r[l].
  - FLUSH: data_out = r.
- All other ops: data_out = data_in, dataB_out = dataB_in (except under SWAP).
- State changes only when valid_in=1 and en=1. Words with valid_in=0 are forwarded with valid_out=0 and leave r/FSM untouched.
- singular clears only on rst or on a valid start_in.

## Timing
- Every output is registered: exactly 1 cycle from input to output when en=1. No combinational path from input to output.
- r updates on the same edge that outputs the word.
- en=0: all registers hold, including valid_out. The upstream stage must stall on the same cycle.
- Reset values:
  - valid_out, start_out, finish_out = 0.
  - op_out = 0, gauss_op_out = PASS.
  - data_out, dataB_out, r = 0.
  - singular = 0, FSM = EMPTY.
- rst mid-frame aborts the frame. The next valid word is handled as if from EMPTY; a new start_in is required for a clean frame.
- Inverse of 0 is defined as 0. It is never emitted, because NORM requires a nonzero pivot.

## Structure
- Shared package gf_pe_pkg holds:
  - opcode and Gauss sub-op encodings;
  - FSM state encoding;
  - the lane slice helper.
- Sub-module gf_pe_lane: one field multiplier plus its r-lane register and data_out mux, instantiated LANES times via generate.
- Single field inverter (lane 0) and the FSM live in the top level.

## Test plan
- GF(16) AES, LANES=4. Pivot PE: start, then row {2,5,0,1} → NORM, dataB_out=9 (inv 2), r={2,5,0,1}, 1-cycle latency.
- Pivot HELD, then row {3,1,1,1} → ELIM, dataB_out=3, data_out={3,1,1,1}.
- Follower with r={1,5,0,9} applies ELIM, dataB=3 → lane0 out 3^3=0, lane1 = 1^(3·5); check against a reference multiplier. Also MAC: 3·7 accumulated into r=0 → 9.
- Pivot PE sees only rows with data_in[0]=0, then finish → all PASS, FLUSH data_out=0, singular=1; next start clears singular.
- en toggled low for 3 cycles mid-frame and valid gaps inserted → output stream identical to the no-stall stream, shifted by exactly the stall count.
- rst asserted while HELD → all outputs 0 and FSM EMPTY next cycle. SWAP ×LANES then returns the loaded values in order on dataB_out.

Source files
------------

// File: rtl/gf_pe_pkg.sv
// gf_pe_pkg: shared encodings, field arithmetic and lane slicing for gf_pe_lanes
package gf_pe_pkg;
  localparam logic [2:0] OP_NOP = 3'd0, OP_GAUSS = 3'd1, OP_LOAD = 3'd3, OP_MAC = 3'd4, OP_SWAP = 3'd5, OP_MULR = 3'd6;
  typedef enum logic [1:0] {G_PASS, G_NORM, G_ELIM, G_FLUSH} gauss_op_e;
  typedef enum logic {S_EMPTY, S_HELD} piv_state_e;
  typedef enum logic [2:0] {R_HOLD, R_ZERO, R_DATA, R_KEY, R_MACK, R_SHIFT, R_MULD, R_MACD} r_op_e;
  typedef enum logic [1:0] {D_IN, D_ZERO, D_R, D_ELIM} d_sel_e;
  function automatic logic [7:0] poly_mul(input logic [7:0] a, input logic [7:0] b, input int w, input logic [8:0] p);
    logic [7:0] acc;
    logic [8:0] x;
    acc = '0;
    x = {1'b0, a};
    for (int i = 0; i < 8; i++) begin
      if (i < w && b[i]) acc ^= x[7:0];
      x = x << 1;
      if (x[w]) x ^= p;
    end
    return acc;
  endfunction
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b, input int w, input bit tower);
    logic [7:0] hm, a0, a1, b0, b1, hh, ll, mx, lam;
    logic [8:0] pi;
    int h;
    if (!tower) return poly_mul(a, b, w, w == 8 ? 9'h11b : 9'h013);
    h = w / 2;
    pi = w == 8 ? 9'h013 : 9'h007;
    lam = w == 8 ? 8'h8 : 8'h2;
    hm = (8'd1 << h) - 8'd1;
    a0 = a & hm;
    a1 = (a >> h) & hm;
    b0 = b & hm;
    b1 = (b >> h) & hm;
    hh = poly_mul(a1, b1, h, pi);
    ll = poly_mul(a0, b0, h, pi);
    mx = poly_mul(a1 ^ a0, b1 ^ b0, h, pi) ^ ll;
    return (mx << h) | (ll ^ poly_mul(lam, hh, h, pi));
  endfunction
  // a^(2^w-2) as the product of a^2, a^4 .. a^(2^(w-1)); maps 0 to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] a, input int w, input bit tower);
    logic [7:0] s, acc;
    s = a;
    acc = 8'd1;
    for (int k = 1; k < 8; k++) begin
      if (k < w) begin
        s = gf_mul(s, s, w, tower);
        acc = gf_mul(acc, s, w, tower);
      end
    end
    return acc;
  endfunction
  function automatic logic [7:0] lane_of(input logic [63:0] v, input int l, input int w);
    return 8'((v >> (l * w)) & ((64'd1 << w) - 64'd1));
  endfunction
endpackage

// File: rtl/gf_pe_lanes_if.sv
// gf_pe_lanes_if: word stream between chained processing elements
interface gf_pe_lanes_if import gf_pe_pkg::*; #(parameter int GF_BIT = 4, parameter int LANES = 4, parameter int OP_CODE_LEN = 4);
  logic valid, start, finish;
  logic [OP_CODE_LEN-1:0] op;
  gauss_op_e gauss_op;
  logic [LANES*GF_BIT-1:0] data;
  logic [GF_BIT-1:0] dataB;
  modport master(output valid, start, finish, op, gauss_op, data, dataB);
  modport slave(input valid, start, finish, op, gauss_op, data, dataB);
endinterface

// File: rtl/gf_pe_lane.sv
// gf_pe_lane: one field multiplier with its accumulator lane and registered data_out
module gf_pe_lane import gf_pe_pkg::*; #(parameter int GF_BIT = 4, parameter bit USE_TOWER_FIELD = 1'b0) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  r_op_e r_op,
  input  d_sel_e d_sel,
  input  logic [GF_BIT-1:0] b,
  input  logic [GF_BIT-1:0] din,
  input  logic [GF_BIT-1:0] key,
  input  logic [GF_BIT-1:0] shift_in,
  output logic [GF_BIT-1:0] r,
  output logic [GF_BIT-1:0] dout
);
  logic [GF_BIT-1:0] r_d, r_q, dout_d, dout_q, m, p;
  always_comb begin
    m = d_sel == D_ELIM ? r_q : r_op == R_MACK ? key : din;
    p = GF_BIT'(gf_mul(8'(b), 8'(m), GF_BIT, USE_TOWER_FIELD));
    case (r_op)
      R_ZERO:  r_d = '0;
      R_DATA:  r_d = din;
      R_KEY:   r_d = key;
      R_MACK:  r_d = r_q ^ p;
      R_SHIFT: r_d = shift_in;
      R_MULD:  r_d = p;
      R_MACD:  r_d = r_q ^ p;
      default: r_d = r_q;
    endcase
    dout_d = d_sel == D_ZERO ? '0 : d_sel == D_R ? r_q : d_sel == D_ELIM ? din ^ p : din;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
      dout_q <= '0;
    end else if (en) begin
      r_q <= r_d;
      dout_q <= dout_d;
    end
  end
  assign r = r_q;
  assign dout = dout_q;
endmodule

// File: rtl/gf_pe_lanes.sv
// gf_pe_lanes: LANES-wide GF(2^GF_BIT) systolic PE with pivot FSM and registered outputs
module gf_pe_lanes import gf_pe_pkg::*; #(
  parameter int GF_BIT = 4,
  parameter int LANES = 4,
  parameter int OP_CODE_LEN = 4,
  parameter bit USE_TOWER_FIELD = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic functionA,
  input  logic [LANES*GF_BIT-1:0] key_data,
  output logic [LANES*GF_BIT-1:0] r,
  output logic singular,
  gf_pe_lanes_if.slave up,
  gf_pe_lanes_if.master dn
);
  logic valid_q, start_q, finish_q, singular_d, singular_q;
  logic [OP_CODE_LEN-1:0] op_q;
  gauss_op_e gop_d, gop_q;
  piv_state_e state_d, state_q;
  logic [GF_BIT-1:0] datab_d, datab_q, d0, d0_inv, rtop;
  logic [(LANES+1)*GF_BIT-1:0] chain;
  r_op_e r_op;
  d_sel_e d_sel;
  assign chain = {r, up.dataB};
  assign rtop = chain[LANES*GF_BIT +: GF_BIT];
  assign d0 = GF_BIT'(lane_of(64'(up.data), 0, GF_BIT));
  assign d0_inv = GF_BIT'(gf_inv(8'(d0), GF_BIT, USE_TOWER_FIELD));
  always_comb begin
    r_op = R_HOLD;
    d_sel = D_IN;
    gop_d = up.gauss_op;
    datab_d = up.dataB;
    state_d = state_q;
    singular_d = singular_q;
    if (up.valid) begin
      if (up.start) singular_d = 1'b0;
      case (up.op[2:0])
        OP_GAUSS:
          if (functionA) begin
            if (up.start) begin
              state_d = S_EMPTY;
              r_op = R_ZERO;
              gop_d = G_PASS;
            end else if (up.finish) begin
              state_d = S_EMPTY;
              gop_d = G_FLUSH;
              d_sel = D_R;
              singular_d = singular_q | (state_q == S_EMPTY);
            end else if (state_q == S_HELD) begin
              gop_d = G_ELIM;
              datab_d = d0;
            end else if (d0 != '0) begin
              state_d = S_HELD;
              r_op = R_DATA;
              gop_d = G_NORM;
              datab_d = d0_inv;
            end else gop_d = G_PASS;
          end else begin
            r_op = up.gauss_op == G_NORM ? R_MULD : R_HOLD;
            d_sel = up.gauss_op == G_NORM ? D_ZERO : up.gauss_op == G_ELIM ? D_ELIM : up.gauss_op == G_FLUSH ? D_R : D_IN;
          end
        OP_LOAD: r_op = R_KEY;
        OP_MAC:  r_op = R_MACK;
        OP_SWAP: begin
          r_op = R_SHIFT;
          datab_d = rtop;
        end
        OP_MULR: r_op = R_MACD;
        default: r_op = R_HOLD;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      start_q <= 1'b0;
      finish_q <= 1'b0;
      op_q <= '0;
      gop_q <= G_PASS;
      datab_q <= '0;
      singular_q <= 1'b0;
      state_q <= S_EMPTY;
    end else if (en) begin
      valid_q <= up.valid;
      start_q <= up.start;
      finish_q <= up.finish;
      op_q <= up.op;
      gop_q <= gop_d;
      datab_q <= datab_d;
      singular_q <= singular_d;
      state_q <= state_d;
    end
  end
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    gf_pe_lane #(.GF_BIT(GF_BIT), .USE_TOWER_FIELD(USE_TOWER_FIELD)) u_lane (
      .clk(clk),
      .rst(rst),
      .en(en),
      .r_op(r_op),
      .d_sel(d_sel),
      .b(up.dataB),
      .din(up.data[l*GF_BIT +: GF_BIT]),
      .key(key_data[l*GF_BIT +: GF_BIT]),
      .shift_in(chain[l*GF_BIT +: GF_BIT]),
      .r(r[l*GF_BIT +: GF_BIT]),
      .dout(dn.data[l*GF_BIT +: GF_BIT])
    );
  end
  assign dn.valid = valid_q;
  assign dn.start = start_q;
  assign dn.finish = finish_q;
  assign dn.op = op_q;
  assign dn.gauss_op = gop_q;
  assign dn.dataB = datab_q;
  assign singular = singular_q;
endmodule

// File: tb/tb_gf_pe_lanes.sv
// tb_gf_pe_lanes: directed GF(16) AES-basis checks of the pivot FSM, follower ops, stall and SWAP chain
module tb_gf_pe_lanes;
  import gf_pe_pkg::*;
  localparam logic [3:0] NOP = 4'd0, GAUSS = 4'd1, LOAD = 4'd3, MAC = 4'd4, SWAP = 4'd5;
  logic clk = 1'b0, rst = 1'b1, en = 1'b1, functionA = 1'b0;
  logic [15:0] key_data = '0, r;
  logic singular;
  int checks = 0, failures = 0;
  gf_pe_lanes_if #(.GF_BIT(4), .LANES(4), .OP_CODE_LEN(4)) up();
  gf_pe_lanes_if #(.GF_BIT(4), .LANES(4), .OP_CODE_LEN(4)) dn();
  gf_pe_lanes #(.GF_BIT(4), .LANES(4), .OP_CODE_LEN(4), .USE_TOWER_FIELD(1'b0)) dut (
    .clk(clk), .rst(rst), .en(en), .functionA(functionA), .key_data(key_data),
    .r(r), .singular(singular), .up(up), .dn(dn)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic v, input logic st, input logic fi, input logic [3:0] op, input logic [1:0] gop, input logic [15:0] d, input logic [3:0] b);
    up.valid = v;
    up.start = st;
    up.finish = fi;
    up.op = op;
    up.gauss_op = gauss_op_e'(gop);
    up.data = d;
    up.dataB = b;
  endtask
  task automatic send(input logic v, input logic st, input logic fi, input logic [3:0] op, input logic [1:0] gop, input logic [15:0] d, input logic [3:0] b);
    drive(v, st, fi, op, gop, d, b);
    @(posedge clk);
    #1;
  endtask
  task automatic expect_out(input string tag, input logic v, input logic [1:0] gop, input logic [15:0] d, input logic [3:0] b);
    check({tag, ".valid"}, 64'(dn.valid), 64'(v));
    check({tag, ".gop"}, 64'(dn.gauss_op), 64'(gop));
    check({tag, ".data"}, 64'(dn.data), 64'(d));
    check({tag, ".dataB"}, 64'(dn.dataB), 64'(b));
  endtask
  initial begin
    drive(1'b0, 1'b0, 1'b0, NOP, 2'd0, 16'h0, 4'h0);
    repeat (2) @(posedge clk);
    #1;
    expect_out("reset", 1'b0, 2'd0, 16'h0, 4'h0);
    check("reset.r", 64'(r), 64'h0);
    check("reset.singular", 64'(singular), 64'h0);
    check("reset.start", 64'(dn.start), 64'h0);
    rst = 1'b0;
    // pivot frame with a valid pivot
    functionA = 1'b1;
    send(1'b1, 1'b1, 1'b0, GAUSS, 2'd0, 16'h0, 4'h0);
    expect_out("piv_start", 1'b1, 2'd0, 16'h0, 4'h0);
    check("piv_start.start", 64'(dn.start), 64'h1);
    send(1'b1, 1'b0, 1'b0, GAUSS, 2'd0, 16'h1052, 4'h0);
    expect_out("piv_norm", 1'b1, 2'd1, 16'h1052, 4'h9);
    check("piv_norm.r", 64'(r), 64'h1052);
    send(1'b1, 1'b0, 1'b0, GAUSS, 2'd0, 16'h1113, 4'h0);
    expect_out("piv_elim", 1'b1, 2'd2, 16'h1113, 4'h3);
    check("piv_elim.r", 64'(r), 64'h1052);
    send(1'b1, 1'b0, 1'b1, GAUSS, 2'd0, 16'h0, 4'h0);
    expect_out("piv_flush", 1'b1, 2'd3, 16'h1052, 4'h0);
    check("piv_flush.finish", 64'(dn.finish), 64'h1);
    check("piv_flush.singular", 64'(singular), 64'h0);
    // frame with no usable pivot
    send(1'b1, 1'b1, 1'b0, GAUSS, 2'd0, 16'h0, 4'h0);
    send(1'b1, 1'b0, 1'b0, GAUSS, 2'd0, 16'h7770, 4'h0);
    expect_out("sing_pass", 1'b1, 2'd0, 16'h7770, 4'h0);
    send(1'b1, 1'b0, 1'b1, GAUSS, 2'd0, 16'h0, 4'h0);
    expect_out("sing_flush", 1'b1, 2'd3, 16'h0, 4'h0);
    check("sing_set", 64'(singular), 64'h1);
    send(1'b1, 1'b1, 1'b0, GAUSS, 2'd0, 16'h0, 4'h0);
    check("sing_clear", 64'(singular), 64'h0);
    // follower: ELIM against r={1,5,0,9}, then NORM and MAC
    functionA = 1'b0;
    key_data = 16'h9051;
    send(1'b1, 1'b0, 1'b0, LOAD, 2'd0, 16'h0, 4'h0);
    check("fol_load.r", 64'(r), 64'h9051);
    send(1'b1, 1'b0, 1'b0, GAUSS, 2'd2, 16'h4213, 4'h3);
    expect_out("fol_elim", 1'b1, 2'd2, 16'hC2E0, 4'h3);
    check("fol_elim.r", 64'(r), 64'h9051);
    send(1'b1, 1'b0, 1'b0, GAUSS, 2'd1, 16'h1052, 4'h2);
    expect_out("fol_norm", 1'b1, 2'd1, 16'h0, 4'h2);
    check("fol_norm.r", 64'(r), 64'h20A4);
    key_data = 16'h0;
    send(1'b1, 1'b0, 1'b0, LOAD, 2'd0, 16'h0, 4'h0);
    key_data = 16'h0007;
    send(1'b1, 1'b0, 1'b0, MAC, 2'd0, 16'h5A5A, 4'h3);
    check("fol_mac.r", 64'(r), 64'h0009);
    check("fol_mac.data", 64'(dn.data), 64'h5A5A);
    // pivot frame with an invalid gap and a 3-cycle stall
    functionA = 1'b1;
    send(1'b1, 1'b1, 1'b0, GAUSS, 2'd0, 16'h0, 4'h0);
    send(1'b1, 1'b0, 1'b0, GAUSS, 2'd0, 16'h3210, 4'h0);
    expect_out("stl_pass", 1'b1, 2'd0, 16'h3210, 4'h0);
    send(1'b0, 1'b0, 1'b0, GAUSS, 2'd1, 16'hFFFF, 4'h6);
    check("stl_gap.valid", 64'(dn.valid), 64'h0);
    check("stl_gap.r", 64'(r), 64'h0);
    send(1'b1, 1'b0, 1'b0, GAUSS, 2'd0, 16'h0004, 4'h0);
    expect_out("stl_norm", 1'b1, 2'd1, 16'h0004, 4'hD);
    en = 1'b0;
    drive(1'b1, 1'b0, 1'b0, GAUSS, 2'd0, 16'h8765, 4'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      expect_out($sformatf("stl_hold%0d", i), 1'b1, 2'd1, 16'h0004, 4'hD);
    end
    check("stl_hold.r", 64'(r), 64'h0004);
    en = 1'b1;
    send(1'b1, 1'b0, 1'b0, GAUSS, 2'd0, 16'h8765, 4'h0);
    expect_out("stl_elim", 1'b1, 2'd2, 16'h8765, 4'h5);
    send(1'b1, 1'b0, 1'b1, GAUSS, 2'd0, 16'h0, 4'h0);
    expect_out("stl_flush", 1'b1, 2'd3, 16'h0004, 4'h0);
    // reset while holding a pivot
    send(1'b1, 1'b1, 1'b0, GAUSS, 2'd0, 16'h0, 4'h0);
    send(1'b1, 1'b0, 1'b0, GAUSS, 2'd0, 16'h0003, 4'h0);
    check("rst_pre.r", 64'(r), 64'h0003);
    rst = 1'b1;
    send(1'b1, 1'b0, 1'b0, GAUSS, 2'd0, 16'h0005, 4'h0);
    expect_out("rst_mid", 1'b0, 2'd0, 16'h0, 4'h0);
    check("rst_mid.r", 64'(r), 64'h0);
    check("rst_mid.op", 64'(dn.op), 64'h0);
    rst = 1'b0;
    send(1'b1, 1'b0, 1'b0, GAUSS, 2'd0, 16'h0006, 4'h0);
    expect_out("rst_empty", 1'b1, 2'd1, 16'h0006, 4'h7);
    // SWAP chain unloads lanes 3..0 and loads the new scalars
    functionA = 1'b0;
    key_data = 16'h4321;
    send(1'b1, 1'b0, 1'b0, LOAD, 2'd0, 16'h0, 4'h0);
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 1'b0, 1'b0, SWAP, 2'd0, 16'h0, 4'(4'hA + i));
      check($sformatf("swap%0d.dataB", i), 64'(dn.dataB), 64'(4 - i));
    end
    check("swap.r", 64'(r), 64'hABCD);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
